// File: rtl/pp_accum_seq_pkg.sv
// pp_accum_seq_pkg: shared sizing defaults, state encoding and accumulator width helper
package pp_accum_seq_pkg;
    localparam int PP_N = 222;
    localparam int PP_K = 3;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    function automatic int acc_w(input int n, input int k);
        return 5 * n / 6 + (k - 1) * n / 3 + 2;
    endfunction
endpackage

// File: rtl/pp_accum_seq_add2.sv
// pp_accum_seq_add2: combines one beat of partial-product slices into a 5N/6-bit value
//   sin, gin, fin, d1 : N/3-bit slices of one beat
//   c                 : combined value {co1 + d1, low half of (gin + 2*fin), sin}
module pp_accum_seq_add2
    import pp_accum_seq_pkg::*;
#(
    parameter int N = PP_N
) (
    input  logic [N/3-1:0]   sin,
    input  logic [N/3-1:0]   gin,
    input  logic [N/3-1:0]   fin,
    input  logic [N/3-1:0]   d1,
    output logic [5*N/6-1:0] c
);
    localparam int S = N / 3;
    localparam int H = N / 6;

    logic [S:0]   mid;
    logic [H:0]   co1;
    logic [S-1:0] hi;

    // gin + 2*fin kept to S+1 bits; everything above the low H bits carries into the top slice
    assign mid = {1'b0, gin} + {fin, 1'b0};
    assign co1 = mid[S:H];
    assign hi  = S'(co1) + d1;
    assign c   = {hi, mid[H-1:0], sin};
endmodule

// File: rtl/pp_accum_seq.sv
// pp_accum_seq: accumulates K shifted partial-product beats into one result with valid/ready handshakes
//   clk, rst             : clock, synchronous active-high reset
//   start, busy          : launch an operation from IDLE; high whenever not IDLE
//   sin, gin, fin, d1    : one beat of N/3-bit slices, accepted on in_valid && in_ready
//   result               : accumulator, held through OUT and the following IDLE
//   out_valid, out_ready : result handshake, completes the operation
module pp_accum_seq
    import pp_accum_seq_pkg::*;
#(
    parameter int N = PP_N,
    parameter int K = PP_K,
    localparam int ACC_W = acc_w(N, K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic [N/3-1:0]   sin,
    input  logic [N/3-1:0]   gin,
    input  logic [N/3-1:0]   fin,
    input  logic [N/3-1:0]   d1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] result,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CW = K > 1 ? $clog2(K) : 1;

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] acc, sh;
    logic [5*N/6-1:0] c;
    logic             take;

    pp_accum_seq_add2 #(.N(N)) u_add2 (
        .sin(sin),
        .gin(gin),
        .fin(fin),
        .d1 (d1),
        .c  (c)
    );

    assign take = in_valid && in_ready;

    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;

    always_comb begin
        nxt       = state;
        busy      = state != IDLE;
        in_ready  = state == ACCUM;
        out_valid = state == OUT;
        result    = acc;
        nxt = state == IDLE  ? (start ? ACCUM : IDLE) :
              state == ACCUM ? (take && cnt == CW'(K - 1) ? OUT : ACCUM) :
                               (out_ready ? IDLE : OUT);
    end

    // one fixed shift per beat position, selected by cnt
    always_comb begin
        sh = '0;
        for (int i = 0; i < K; i++)
            if (cnt == CW'(i)) sh = ACC_W'(c) << (i * N / 3);
    end

    always_ff @(posedge clk)
        if (rst || (state == IDLE && start)) begin
            acc <= '0;
            cnt <= '0;
        end else if (take) begin
            acc <= acc + sh;
            cnt <= cnt + CW'(1);
        end
endmodule

// File: tb/tb_pp_accum_seq.sv
// tb_pp_accum_seq: randomized self-checking bench for pp_accum_seq against an arithmetic reference
module tb_pp_accum_seq;
    localparam int N  = 12;
    localparam int K  = 3;
    localparam int S  = N / 3;
    localparam int AW = 5 * N / 6 + (K - 1) * N / 3 + 2;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, out_ready;
    logic          busy, in_ready, out_valid;
    logic [S-1:0]  sin, gin, fin, d1;
    logic [AW-1:0] result;

    int tests = 0;
    int fails = 0;
    int bs[K], bg[K], bf[K], bd[K];

    always #5 clk = ~clk;

    pp_accum_seq #(.N(N), .K(K)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .sin      (sin),
        .gin      (gin),
        .fin      (fin),
        .d1       (d1),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .result   (result),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // value of one beat from the combine rules: low slice sin, then gin+2*fin (S+1 bits),
    // whose bits above the lowest N/6 are added to d1 in the top slice
    function automatic longint cval(input int s, input int g, input int f, input int d);
        int m;
        m = (g + 2 * f) % (1 << (S + 1));
        return longint'(((m / (1 << (N / 6))) + d) % (1 << S)) * (1 << (S + N / 6))
             + longint'(m % (1 << (N / 6))) * (1 << S) + longint'(s);
    endfunction

    function automatic longint model();
        longint a = 0;
        for (int j = 0; j < K; j++) a += cval(bs[j], bg[j], bf[j], bd[j]) << (S * j);
        return a & ((64'd1 << AW) - 1);
    endfunction

    task automatic rand_beats();
        for (int j = 0; j < K; j++) begin
            bs[j] = $urandom_range(0, (1 << S) - 1);
            bg[j] = $urandom_range(0, (1 << S) - 1);
            bf[j] = $urandom_range(0, (1 << S) - 1);
            bd[j] = $urandom_range(0, (1 << S) - 1);
        end
    endtask

    task automatic drive_beat(input int j, input logic v);
        in_valid = v;
        sin = v ? S'(bs[j]) : S'($urandom);
        gin = v ? S'(bg[j]) : S'($urandom);
        fin = v ? S'(bf[j]) : S'($urandom);
        d1  = v ? S'(bd[j]) : S'($urandom);
    endtask

    // gap: 0 none, 1 random, 2 fixed 1,0,0,1,1; bp: cycles of out_ready=0; junk: stray start/beats
    task automatic op(input int gap, input int bp, input bit junk);
        longint        exp;
        int            j, g;
        logic [4:0]    pat;
        logic [AW-1:0] held;
        exp = model();
        j   = 0;
        g   = 0;
        pat = 5'b11001;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_lat", in_ready, 1);
        check("busy_run", busy, 1);
        while (j < K && g < 40) begin
            drive_beat(j, gap == 0 ? 1'b1 : gap == 1 ? 1'($urandom_range(0, 1)) : (g < 5 ? pat[g] : 1'b1));
            start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (in_valid) j++;
            g++;
        end
        check("beats", j, K);
        if (gap == 2) check("gap_cycles", g, 5);
        drive_beat(0, junk);
        start = junk;
        check("out_lat", out_valid, 1);
        check("result", result, exp);
        held = result;
        for (int i = 0; i < bp; i++) begin
            out_ready = 1'b0;
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_stable", result, held);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        check("idle_ready", in_ready, 0);
        check("idle_result", result, exp);
    endtask

    initial begin
        logic [AW-1:0] r0;
        longint        exp;
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        sin = '1; gin = '1; fin = '1; d1 = '1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("idle_hold", busy, 0);

        bs = '{1, 1, 1}; bg = '{0, 0, 0}; bf = '{0, 0, 0}; bd = '{0, 0, 0};
        op(0, 0, 0);
        check("sin_sum", result, 'h00111);

        bs = '{0, 0, 0}; bg = '{15, 0, 0}; bf = '{15, 0, 0}; bd = '{0, 0, 0};
        op(0, 0, 0);
        check("carry", result, 'h000D0);

        rand_beats();
        op(0, 5, 0);

        rand_beats();
        op(0, 0, 0);
        r0 = result;
        op(2, 0, 0);
        check("gap_eq", result, r0);

        rand_beats();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            drive_beat(j, 1'b1);
            tick();
        end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_ready", in_ready, 0);
        exp = model();
        op(0, 0, 0);
        check("after_rst", result, exp);

        rand_beats();
        op(1, 2, 1);

        for (int t = 0; t < 25; t++) begin
            rand_beats();
            op($urandom_range(0, 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
